// File: rtl/demux1to4_buf.sv
// -----------------------------------------------------------------------------
// demux1to4_buf
//
// Registered 1-to-4 distributor with one-hot (priority) select. One input word
// stream is steered into four independently handshaked output channels, each
// backed by a one-entry output register. A stalled consumer only blocks words
// addressed to its own channel.
//
// Ports
//   clk                     system clock, all state on the rising edge
//   rst                     synchronous, active-high reset
//   in_data   [N-1:0]       input word
//   in_valid                in_data is valid this cycle
//   in_ready                the block accepts in_data this cycle
//   sel0..sel3              channel select, sel0 highest priority
//   out0..out3 [N-1:0]      channel data registers
//   out_valid0..out_valid3  channel register holds an undelivered word
//   out_ready0..out_ready3  consumer takes the word this cycle
//   drop_cnt  [DROP_W-1:0]  saturating count of words accepted with no select
// -----------------------------------------------------------------------------
module demux1to4_buf #(
  parameter int N      = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sel0,
  input  logic              sel1,
  input  logic              sel2,
  input  logic              sel3,
  output logic [N-1:0]      out0,
  output logic [N-1:0]      out1,
  output logic [N-1:0]      out2,
  output logic [N-1:0]      out3,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  input  logic              out_ready0,
  input  logic              out_ready1,
  input  logic              out_ready2,
  input  logic              out_ready3,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    CH0     = 3'd0,
    CH1     = 3'd1,
    CH2     = 3'd2,
    CH3     = 3'd3,
    CH_NONE = 3'd4
  } ch_e;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  ch_e              ch;
  logic [3:0]       out_ready;
  logic [3:0]       valid_q;
  logic [N-1:0]     data_q [4];
  logic [3:0]       space;
  logic [3:0]       load;
  logic             drop;
  logic [DROP_W-1:0] drop_q;

  assign out_ready = {out_ready3, out_ready2, out_ready1, out_ready0};

  // A channel can take a new word if it is empty or its current word is being
  // delivered this cycle; this is what gives zero-bubble streaming.
  assign space = ~valid_q | out_ready;

  // Priority decode: lowest index wins when several selects are high.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ch = CH_NONE;
    if (sel0)      ch = CH0;
    else if (sel1) ch = CH1;
    else if (sel2) ch = CH2;
    else if (sel3) ch = CH3;
  end

  // in_ready looks only at the decoded channel, never at in_valid, so the
  // producer sees a stable ready while it holds its word.
  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    drop     = 1'b0;
    case (ch)
      CH0:     begin in_ready = space[0]; load[0] = in_valid & space[0]; end
      CH1:     begin in_ready = space[1]; load[1] = in_valid & space[1]; end
      CH2:     begin in_ready = space[2]; load[2] = in_valid & space[2]; end
      CH3:     begin in_ready = space[3]; load[3] = in_valid & space[3]; end
      default: drop = in_valid;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      drop_q  <= '0;
      // NOTE: the data registers are reset too because the channel words are
      // externally visible and must read zero after reset.
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] && out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (drop && (drop_q != DROP_MAX)) drop_q <= drop_q + 1'b1;
    end
  end

  assign out0       = data_q[0];
  assign out1       = data_q[1];
  assign out2       = data_q[2];
  assign out3       = data_q[3];
  assign out_valid0 = valid_q[0];
  assign out_valid1 = valid_q[1];
  assign out_valid2 = valid_q[2];
  assign out_valid3 = valid_q[3];
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1to4_buf
//
// Self-checking bench for demux1to4_buf: a table of directed vectors with
// hand-computed expectations, followed by hand-written sequences for
// streaming, drop-counter saturation and reset priority.
// -----------------------------------------------------------------------------
module tb_demux1to4_buf;

  localparam int N      = 16;
  localparam int DROP_W = 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        sel;
  logic [3:0]        ordy;
  logic [N-1:0]      out0, out1, out2, out3;
  logic              out_valid0, out_valid1, out_valid2, out_valid3;
  logic [DROP_W-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  demux1to4_buf #(.N(N), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel0       (sel[0]),
    .sel1       (sel[1]),
    .sel2       (sel[2]),
    .sel3       (sel[3]),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_valid3 (out_valid3),
    .out_ready0 (ordy[0]),
    .out_ready1 (ordy[1]),
    .out_ready2 (ordy[2]),
    .out_ready3 (ordy[3]),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         in_valid;
    logic [15:0]  in_data;
    logic [3:0]   sel;
    logic [3:0]   ordy;
    logic         exp_ir;
    logic [3:0]   exp_v;
    logic [15:0]  exp_o0, exp_o1, exp_o2, exp_o3;
    logic [7:0]   exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [15:0] d, logic [3:0] s,
                              logic [3:0] rd, logic ir, logic [3:0] v,
                              logic [15:0] o0, logic [15:0] o1,
                              logic [15:0] o2, logic [15:0] o3, logic [7:0] dc);
    vec_t t;
    t.rst = r; t.in_valid = iv; t.in_data = d; t.sel = s; t.ordy = rd;
    t.exp_ir = ir; t.exp_v = v;
    t.exp_o0 = o0; t.exp_o1 = o1; t.exp_o2 = o2; t.exp_o3 = o3;
    t.exp_drop = dc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] vbits();
    return {out_valid3, out_valid2, out_valid1, out_valid0};
  endfunction

  // Drive at the falling edge, check in_ready just after, then check the
  // registered outputs 1 time unit after the next rising edge.
  task automatic drive(input logic r, input logic iv, input logic [15:0] d,
                       input logic [3:0] s, input logic [3:0] rd);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; sel = s; ordy = rd;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] v,
                            input logic [15:0] o0, input logic [15:0] o1,
                            input logic [15:0] o2, input logic [15:0] o3,
                            input logic [7:0] dc);
    check({tag, " out_valid"}, 32'(vbits()), 32'(v));
    check({tag, " out0"}, 32'(out0), 32'(o0));
    check({tag, " out1"}, 32'(out1), 32'(o1));
    check({tag, " out2"}, 32'(out2), 32'(o2));
    check({tag, " out3"}, 32'(out3), 32'(o3));
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; ordy = '0;

    //                r  iv data      sel      ordy     ir v        o0       o1       o2       o3       drop
    vecs.push_back(mk(1, 0, 16'h0000, 4'b0000, 4'b0000, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    // first load to channel 2
    vecs.push_back(mk(0, 1, 16'hA5A5, 4'b0100, 4'b0000, 1, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 0));
    // channel 2 full and stalled: word waits, register held
    vecs.push_back(mk(0, 1, 16'h1234, 4'b0100, 4'b0000, 0, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 0));
    // consumer ready: same-cycle drain and load
    vecs.push_back(mk(0, 1, 16'h1234, 4'b0100, 4'b0100, 1, 4'b0100, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0));
    // sel1 and sel3: channel 1 wins
    vecs.push_back(mk(0, 1, 16'h00FF, 4'b1010, 4'b0000, 1, 4'b0110, 16'h0000, 16'h00FF, 16'h1234, 16'h0000, 0));
    // drain everything, data kept
    vecs.push_back(mk(0, 0, 16'h0000, 4'b0000, 4'b1111, 1, 4'b0000, 16'h0000, 16'h00FF, 16'h1234, 16'h0000, 0));
    // in_valid low with a select: no load
    vecs.push_back(mk(0, 0, 16'hFFFF, 4'b1000, 4'b0000, 1, 4'b0000, 16'h0000, 16'h00FF, 16'h1234, 16'h0000, 0));
    // no select: dropped and counted
    vecs.push_back(mk(0, 1, 16'h5555, 4'b0000, 4'b0000, 1, 4'b0000, 16'h0000, 16'h00FF, 16'h1234, 16'h0000, 1));
    // all selects: channel 0 wins
    vecs.push_back(mk(0, 1, 16'h0A0A, 4'b1111, 4'b0000, 1, 4'b0001, 16'h0A0A, 16'h00FF, 16'h1234, 16'h0000, 1));
    // channel 0 blocked; out_ready1 on an empty channel has no effect
    vecs.push_back(mk(0, 1, 16'h0B0B, 4'b0001, 4'b0010, 0, 4'b0001, 16'h0A0A, 16'h00FF, 16'h1234, 16'h0000, 1));
    // re-decode the stalled word to channel 1
    vecs.push_back(mk(0, 1, 16'h0B0B, 4'b0010, 4'b0000, 1, 4'b0011, 16'h0A0A, 16'h0B0B, 16'h1234, 16'h0000, 1));
    // load+drain channel 0 while channel 1 drains independently
    vecs.push_back(mk(0, 1, 16'h0C0C, 4'b0001, 4'b0011, 1, 4'b0001, 16'h0C0C, 16'h0B0B, 16'h1234, 16'h0000, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data, vecs[i].sel, vecs[i].ordy);
      check({tag, " in_ready"}, 32'(in_ready), 32'(vecs[i].exp_ir));
      after_edge();
      check_outs(tag, vecs[i].exp_v, vecs[i].exp_o0, vecs[i].exp_o1,
                 vecs[i].exp_o2, vecs[i].exp_o3, vecs[i].exp_drop);
    end

    // Streaming: 8 words to channel 0 with a continuously ready consumer.
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 16'(i), 4'b0001, 4'b0001);
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      after_edge();
      check($sformatf("stream%0d out_valid0", i), 32'(out_valid0), 32'd1);
      check($sformatf("stream%0d out0", i), 32'(out0), 32'(i));
    end
    drive(0, 0, 16'h0000, 4'b0000, 4'b0001);
    after_edge();
    check_outs("stream_end", 4'b0000, 16'h0008, 16'h0B0B, 16'h1234, 16'h0000, 1);

    // 300 dropped words: counter starts at 1 and must saturate at 255.
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 16'(i), 4'b0000, 4'b0000);
      check($sformatf("drop%0d in_ready", i), 32'(in_ready), 32'd1);
      after_edge();
      check($sformatf("drop%0d out_valid", i), 32'(vbits()), 32'd0);
    end
    check("drop saturated", 32'(drop_cnt), 32'd255);

    // Reset wins over a simultaneous accept and drain.
    drive(0, 1, 16'hBEEF, 4'b1000, 4'b0000);
    check("beef in_ready", 32'(in_ready), 32'd1);
    after_edge();
    check_outs("beef", 4'b1000, 16'h0008, 16'h0B0B, 16'h1234, 16'hBEEF, 255);
    drive(1, 1, 16'h1111, 4'b0001, 4'b1000);
    after_edge();
    check_outs("rst_prio", 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    drive(0, 0, 16'h0000, 4'b0000, 4'b0000);
    after_edge();
    check_outs("post_rst", 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Registered 1-to-4 distributor with one-hot select. It steers one input word stream into four independently handshaked output channels.
- It is the write-side counterpart of the datapath 4-to-1 priority mux: a producer fans a word out to one of four consumers, and each consumer then drains its channel at its own pace.
- Each channel holds a one-entry output register, so a stalled consumer blocks only traffic addressed to it.

Parameters:
- N, 16, data width in bits of the input word and of every output word.
- DROP_W, 8, width of the saturating counter for words dropped because no select was asserted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  input word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  the block accepts in_data this cycle.
- sel0  input  1  route to channel 0; highest priority.
- sel1  input  1  route to channel 1.
- sel2  input  1  route to channel 2.
- sel3  input  1  route to channel 3; lowest priority.
- out0, out1, out2, out3  output  N each  channel data registers.
- out_valid0..out_valid3  output  1 each  channel register holds an undelivered word.
- out_ready0..out_ready3  input  1 each  consumer takes the word this cycle.
- drop_cnt  output  DROP_W  count of words accepted with no select asserted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid0..3 = 0, out0..3 = 0, drop_cnt = 0.
  - rst has priority over every other event, including an accept or drain in the same cycle.
  - A word held in a channel at reset is discarded.
- Channel decode, combinational each cycle, same priority as the mux:
  - ch = 0 if sel0, else 1 if sel1, else 2 if sel2, else 3 if sel3, else NONE.
  - Multiple selects: the lowest index wins. This is not an error.
- Per-channel space: space_k = ~out_valid_k | out_ready_k. Loading while draining in the same cycle is allowed.
- in_ready = space_ch when ch is 0..3; in_ready = 1 when ch = NONE.
  - in_ready depends combinationally on the sel inputs and on out_ready of the decoded channel only. It does not depend on in_valid.
- Accept: accept = in_valid & in_ready. sel and in_data are sampled in the accept cycle only.
- Load on accept to channel k, at the next edge: out_k <= in_data, out_valid_k <= 1. Latency is 1 cycle from accept to visible out_valid_k.
- Drain: out_valid_k & out_ready_k with no load to k that cycle -> out_valid_k <= 0. out_k keeps its old value (don't-care once invalid).
- Simultaneous drain and load on the same k: the word delivered this cycle is the old out_k. The new word is registered, and out_valid_k stays 1. Zero bubble, so a continuously ready consumer sustains 1 word/cycle.
- Stability: while out_valid_k = 1 and out_ready_k = 0, out_k is held stable.
- Blocked channels: a word to a blocked channel has in_ready = 0 and waits. The producer holds in_data, in_valid and sel stable until accept.
  - Changing sel while stalled is permitted; the word re-decodes to the new channel.
- Non-selected channels: they drain independently in the same cycle as any accept.
- ch = NONE with in_valid = 1: the word is accepted and discarded. drop_cnt increments and saturates at 2^DROP_W-1 with no wrap. drop_cnt clears only on rst.
- in_valid = 0: no load and no drop, whatever the sel inputs are.
- out_ready_k while out_valid_k = 0 has no effect.

Test Plan:
- Reset, then in_valid=1, in_data=16'hA5A5, sel2=1, all out_ready=0 -> in_ready=1. Next cycle out_valid2=1 and out2=16'hA5A5; other out_valid=0.
- With channel 2 full and out_ready2=0, present 16'h1234 on sel2 -> in_ready=0 and out2 held at 16'hA5A5. Raise out_ready2 -> same-cycle accept; next cycle out2=16'h1234 and out_valid2=1.
- sel1=sel3=1 with 16'h00FF -> word lands in channel 1 only; out_valid3 stays 0.
- Stream 8 words 1..8 to channel 0 with out_ready0=1 every cycle -> in_ready=1 throughout; out0 shows 1..8 on consecutive cycles with no gap.
- 300 words with no select asserted -> in_ready=1 each cycle, no out_valid rises, drop_cnt=255 (saturated).
- Load channel 3 with 16'hBEEF, then assert rst in the same cycle as a new accept to channel 0 and out_ready3=1 -> next cycle all out_valid=0, all out=0, drop_cnt=0.
